// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared types and constants for the branch predictor slice: the BTB entry
// record, 2-bit counter encodings, field positions inside the PCpipe
// resolution bus and the fall-through alignment helper.
//
// Bit numbering note: the branch unit documents its buses MSB-first
// ([0:31], [0:65]). Everything here is declared descending ([31:0],
// [65:0]) so bit 0 of the documented layout is the MSB of our vectors.
// Numeric values are identical either way.
// ---------------------------------------------------------------------------
package bp_pkg;

    // 2-bit saturating counter states; the MSB is the taken prediction
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // PCpipe layout {target[31:0], taken, branchPc[31:0], mispredict}
    localparam int PCPIPE_W         = 66;
    localparam int PCPIPE_TARGET_HI = 65;
    localparam int PCPIPE_TARGET_LO = 34;
    localparam int PCPIPE_TAKEN     = 33;
    localparam int PCPIPE_BRPC_HI   = 32;
    localparam int PCPIPE_BRPC_LO   = 1;
    localparam int PCPIPE_MISP      = 0;

    // Fall-through is the next 8-byte aligned fetch group
    localparam logic [31:0] FT_MASK = 32'hFFFF_FFF8;

    // The tag holds the whole word address. The index bits inside it always
    // equal the entry's own index, so comparing all 30 bits is the same as
    // comparing only the upper tag bits, and the record stays independent
    // of the table size.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btbEntry_t;

    function automatic logic [31:0] fallThrough(input logic [31:0] pc);
        return (pc + 32'd8) & FT_MASK;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// ---------------------------------------------------------------------------
// bp_sat_ctr
// Combinational next-state function of a 2-bit saturating counter.
// Ports:
//   i_ctr     [1:0]  current counter value
//   i_taken          resolved direction
//   o_ctrNext [1:0]  counter after training (saturates at 00 / 11)
// ---------------------------------------------------------------------------
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctrNext
);

    // Step toward the resolved direction, holding at either end
    always_comb begin
        o_ctrNext = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST) begin
                o_ctrNext = i_ctr + 2'd1;
            end
        end else begin
            if (i_ctr != CTR_SNT) begin
                o_ctrNext = i_ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB with a 2-bit saturating counter per entry. Looks up the
// fetch PC and registers a prediction one cycle later; trains on the branch
// unit's PCpipe resolution bus and pulses a redirect on mispredict.
//
// Parameters:
//   ENTRIES  number of BTB entries (power of two, 4..256)
//   IDX_W    index width, derived from ENTRIES
// Ports:
//   clk, reset                    clock / async active-high reset
//   fetch_valid, fetch_pc         lookup request
//   predict_valid, predict,
//   predict_pc                    registered prediction for last lookup
//   resolve_valid, PCpipe         resolved branch {target,taken,pc,misp}
//   redirect, redirect_pc         one-cycle restart pulse and PC
//   stat_branches,
//   stat_mispredicts              event counters
// Build option:
//   BP_STATS_EN  when defined, the two stat outputs count resolved branches
//                and mispredicts; otherwise they are tied to zero.
// ---------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_valid,
    input  logic [31:0]         fetch_pc,
    output logic                predict_valid,
    output logic                predict,
    output logic [31:0]         predict_pc,
    input  logic                resolve_valid,
    input  logic [PCPIPE_W-1:0] PCpipe,
    output logic                redirect,
    output logic [31:0]         redirect_pc,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    btbEntry_t r_btb [ENTRIES];

    logic             r_predictValid;
    logic             r_predict;
    logic [31:0]      r_predictPc;
    logic             r_redirect;
    logic [31:0]      r_redirectPc;

    logic [IDX_W-1:0] w_fetchIdx;
    btbEntry_t        w_lookEntry;
    logic             w_lookTaken;

    logic [31:0]      w_resTarget;
    logic             w_resTaken;
    logic [31:0]      w_resPc;
    logic [IDX_W-1:0] w_resIdx;
    btbEntry_t        w_resEntry;
    logic             w_resHit;
    logic             w_mispredict;
    logic [1:0]       w_ctrNext;
    logic [1:0]       w_unusedResPcBits;

    // Lookup reads the table as it stands this cycle, so a same-cycle update
    // is not visible until the next lookup
    assign w_fetchIdx  = fetch_pc[IDX_W+1:2];
    assign w_lookEntry = r_btb[w_fetchIdx];
    assign w_lookTaken = w_lookEntry.valid && (w_lookEntry.tag == fetch_pc[31:2])
                         && w_lookEntry.ctr[1];

    assign w_resTarget       = PCpipe[PCPIPE_TARGET_HI:PCPIPE_TARGET_LO];
    assign w_resTaken        = PCpipe[PCPIPE_TAKEN];
    assign w_resPc           = PCpipe[PCPIPE_BRPC_HI:PCPIPE_BRPC_LO];
    assign w_resIdx          = w_resPc[IDX_W+1:2];
    assign w_resEntry        = r_btb[w_resIdx];
    assign w_resHit          = w_resEntry.valid && (w_resEntry.tag == w_resPc[31:2]);
    assign w_mispredict      = resolve_valid && PCpipe[PCPIPE_MISP];
    assign w_unusedResPcBits = w_resPc[1:0];

    bp_sat_ctr u_satCtr (
        .i_ctr     (w_resEntry.ctr),
        .i_taken   (w_resTaken),
        .o_ctrNext (w_ctrNext)
    );

    // Prediction and redirect registers. A lookup made in a mispredict
    // resolve cycle is on the wrong path, so its predict_valid is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_predictValid <= 1'b0;
            r_predict      <= 1'b0;
            r_predictPc    <= '0;
            r_redirect     <= 1'b0;
            r_redirectPc   <= '0;
        end else begin
            r_predictValid <= fetch_valid && !w_mispredict;
            if (fetch_valid) begin
                r_predict   <= w_lookTaken;
                r_predictPc <= w_lookTaken ? w_lookEntry.target : fallThrough(fetch_pc);
            end
            r_redirect <= w_mispredict;
            if (w_mispredict) begin
                r_redirectPc <= w_resTarget;
            end
        end
    end

    // Table training: hits walk the counter, taken misses allocate as weak
    // taken, not-taken misses leave the table alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (resolve_valid) begin
            if (w_resHit) begin
                r_btb[w_resIdx].ctr <= w_ctrNext;
                if (w_resTaken) begin
                    r_btb[w_resIdx].target <= w_resTarget;
                end
            end else if (w_resTaken) begin
                r_btb[w_resIdx] <= '{valid: 1'b1, tag: w_resPc[31:2],
                                     target: w_resTarget, ctr: CTR_WT};
            end
        end
    end

    assign predict_valid = r_predictValid;
    assign predict       = r_predict;
    assign predict_pc    = r_predictPc;
    assign redirect      = r_redirect;
    assign redirect_pc   = r_redirectPc;

`ifdef BP_STATS_EN
    logic [31:0] r_statBranches;
    logic [31:0] r_statMispredicts;

    // Free-running event counters, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_statBranches    <= '0;
            r_statMispredicts <= '0;
        end else if (resolve_valid) begin
            r_statBranches <= r_statBranches + 32'd1;
            if (PCpipe[PCPIPE_MISP]) begin
                r_statMispredicts <= r_statMispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_statBranches;
    assign stat_mispredicts = r_statMispredicts;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed, table-driven bench for branch_predictor (ENTRIES = 16). Each
// table row is applied for one cycle and the registered outputs are checked
// one time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        predict_valid;
    logic        predict;
    logic [31:0] predict_pc;
    logic        resolve_valid;
    logic [65:0] PCpipe;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int nChecks = 0;
    int nFails  = 0;
    int expBranches = 0;
    int expMisp     = 0;

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        rv;
        logic [65:0] pipe;
        logic        ePv;
        logic        eP;
        logic [31:0] ePpc;
        logic        eRd;
        logic [31:0] eRpc;
    } vec_t;

    vec_t vecs[$];

    branch_predictor #(.ENTRIES(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .predict_valid    (predict_valid),
        .predict          (predict),
        .predict_pc       (predict_pc),
        .resolve_valid    (resolve_valid),
        .PCpipe           (PCpipe),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    function automatic logic [65:0] mkPipe(input logic [31:0] target, input logic taken,
                                           input logic [31:0] brpc, input logic misp);
        return {target, taken, brpc, misp};
    endfunction

    function automatic vec_t mkVec(input logic fv, input logic [31:0] fpc, input logic rv,
                                   input logic [65:0] pipe, input logic ePv, input logic eP,
                                   input logic [31:0] ePpc, input logic eRd,
                                   input logic [31:0] eRpc);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.rv = rv; v.pipe = pipe;
        v.ePv = ePv; v.eP = eP; v.ePpc = ePpc; v.eRd = eRd; v.eRpc = eRpc;
        return v;
    endfunction

    function automatic vec_t lookupVec(input logic [31:0] pc, input logic eP,
                                       input logic [31:0] ePpc);
        return mkVec(1'b1, pc, 1'b0, '0, 1'b1, eP, ePpc, 1'b0, 32'h0);
    endfunction

    function automatic vec_t resolveVec(input logic [31:0] target, input logic taken,
                                        input logic [31:0] brpc, input logic misp);
        return mkVec(1'b0, 32'h0, 1'b1, mkPipe(target, taken, brpc, misp),
                     1'b0, 1'b0, 32'h0, misp, target);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one row for a cycle, then land 1 time unit past the next edge
    task automatic applyStimulus(input vec_t v);
        fetch_valid   = v.fv;
        fetch_pc      = v.fpc;
        resolve_valid = v.rv;
        PCpipe        = v.pipe;
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        fetch_valid   = 1'b0;
        fetch_pc      = '0;
        resolve_valid = 1'b0;
        PCpipe        = '0;
    endtask

    task automatic checkStats(input string tag, input int br, input int mp);
`ifdef BP_STATS_EN
        checkOutput({tag, " stat_branches"}, stat_branches, 32'(br));
        checkOutput({tag, " stat_mispredicts"}, stat_mispredicts, 32'(mp));
`else
        checkOutput({tag, " stat_branches"}, stat_branches, 32'h0);
        checkOutput({tag, " stat_mispredicts"}, stat_mispredicts, 32'h0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();

        // Directed sequence; rows run back to back
        vecs.push_back(lookupVec(32'h100, 1'b0, 32'h108));                 // cold miss
        vecs.push_back(resolveVec(32'h200, 1'b1, 32'h100, 1'b1));          // allocate + redirect
        vecs.push_back(lookupVec(32'h100, 1'b1, 32'h200));                 // hit, ctr 10
        vecs.push_back(resolveVec(32'h200, 1'b1, 32'h100, 1'b0));          // ctr 11
        vecs.push_back(resolveVec(32'h200, 1'b1, 32'h100, 1'b0));          // ctr 11
        vecs.push_back(resolveVec(32'h240, 1'b1, 32'h100, 1'b0));          // ctr 11, new target
        vecs.push_back(lookupVec(32'h100, 1'b1, 32'h240));
        vecs.push_back(resolveVec(32'h104, 1'b0, 32'h100, 1'b0));          // ctr 10
        vecs.push_back(lookupVec(32'h100, 1'b1, 32'h240));
        vecs.push_back(resolveVec(32'h104, 1'b0, 32'h100, 1'b0));          // ctr 01
        vecs.push_back(lookupVec(32'h100, 1'b0, 32'h108));
        vecs.push_back(resolveVec(32'h104, 1'b0, 32'h100, 1'b0));          // ctr 00
        vecs.push_back(resolveVec(32'h104, 1'b0, 32'h100, 1'b0));          // ctr stays 00
        vecs.push_back(resolveVec(32'h240, 1'b1, 32'h100, 1'b0));          // ctr 01
        vecs.push_back(lookupVec(32'h100, 1'b0, 32'h108));
        vecs.push_back(resolveVec(32'h240, 1'b1, 32'h100, 1'b0));          // ctr 10
        vecs.push_back(lookupVec(32'h100, 1'b1, 32'h240));
        // same-cycle lookup and allocate: lookup sees old contents
        vecs.push_back(mkVec(1'b1, 32'h108, 1'b1, mkPipe(32'h400, 1'b1, 32'h108, 1'b0),
                             1'b1, 1'b0, 32'h110, 1'b0, 32'h0));
        vecs.push_back(lookupVec(32'h108, 1'b1, 32'h400));
        // aliasing: 0x500 shares index 0 with 0x100
        vecs.push_back(resolveVec(32'h600, 1'b1, 32'h500, 1'b0));
        vecs.push_back(lookupVec(32'h100, 1'b0, 32'h108));
        vecs.push_back(lookupVec(32'h500, 1'b1, 32'h600));
        vecs.push_back(resolveVec(32'h704, 1'b0, 32'h700, 1'b0));          // NT miss: no change
        vecs.push_back(lookupVec(32'h500, 1'b1, 32'h600));
        // PCpipe ignored without resolve_valid
        vecs.push_back(mkVec(1'b0, 32'h0, 1'b0, mkPipe(32'h900, 1'b1, 32'h500, 1'b1),
                             1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
        vecs.push_back(lookupVec(32'h500, 1'b1, 32'h600));
        // mispredict with a lookup in the same cycle: lookup squashed
        vecs.push_back(mkVec(1'b1, 32'h200, 1'b1, mkPipe(32'h800, 1'b0, 32'h108, 1'b1),
                             1'b0, 1'b0, 32'h0, 1'b1, 32'h800));
        vecs.push_back(lookupVec(32'h108, 1'b0, 32'h110));                 // ctr 01
        // back-to-back mispredicts, each with its own pulse
        vecs.push_back(resolveVec(32'hA00, 1'b1, 32'h30C, 1'b1));          // allocate, ctr 10
        vecs.push_back(resolveVec(32'hA04, 1'b1, 32'h30C, 1'b1));          // sees alloc: ctr 11
        vecs.push_back(resolveVec(32'hA08, 1'b0, 32'h30C, 1'b0));          // ctr 10
        vecs.push_back(lookupVec(32'h30C, 1'b1, 32'hA04));
        vecs.push_back(lookupVec(32'h30F, 1'b1, 32'hA04));                 // low bits ignored
        vecs.push_back(lookupVec(32'h1234, 1'b0, 32'h1238));               // unaligned fall-through
        vecs.push_back(mkVec(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset predict_valid", {31'h0, predict_valid}, 32'h0);
        checkOutput("reset predict", {31'h0, predict}, 32'h0);
        checkOutput("reset predict_pc", predict_pc, 32'h0);
        checkOutput("reset redirect", {31'h0, redirect}, 32'h0);
        checkOutput("reset redirect_pc", redirect_pc, 32'h0);
        checkStats("reset", 0, 0);
        reset = 1'b0;

        $display("[TB] running %0d table rows", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].rv) begin
                expBranches++;
                if (vecs[i].pipe[0]) expMisp++;
            end
            checkOutput($sformatf("row%0d predict_valid", i), {31'h0, predict_valid},
                        {31'h0, vecs[i].ePv});
            if (vecs[i].ePv) begin
                checkOutput($sformatf("row%0d predict", i), {31'h0, predict}, {31'h0, vecs[i].eP});
                checkOutput($sformatf("row%0d predict_pc", i), predict_pc, vecs[i].ePpc);
            end
            checkOutput($sformatf("row%0d redirect", i), {31'h0, redirect}, {31'h0, vecs[i].eRd});
            if (vecs[i].eRd) begin
                checkOutput($sformatf("row%0d redirect_pc", i), redirect_pc, vecs[i].eRpc);
            end
        end
        checkStats("table", expBranches, expMisp);

        // Async reset while a redirect pulse is showing clears it at once
        applyStimulus(resolveVec(32'hC00, 1'b0, 32'h30C, 1'b1));
        checkOutput("pre-reset redirect", {31'h0, redirect}, 32'h1);
        checkStats("pre-reset", expBranches + 1, expMisp + 1);
        idleInputs();
        reset = 1'b1;
        #1;
        checkOutput("async reset redirect", {31'h0, redirect}, 32'h0);
        checkOutput("async reset redirect_pc", redirect_pc, 32'h0);
        checkStats("async reset", 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset raised inside a mispredict resolve cycle aborts everything
        fetch_valid   = 1'b0;
        resolve_valid = 1'b1;
        PCpipe        = mkPipe(32'hD00, 1'b1, 32'h100, 1'b1);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resolve-cycle reset redirect", {31'h0, redirect}, 32'h0);
        checkStats("resolve-cycle reset", 0, 0);
        idleInputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post-reset redirect", {31'h0, redirect}, 32'h0);

        // Table was invalidated and the aborted resolve never allocated
        applyStimulus(lookupVec(32'h30C, 1'b0, 32'h310));
        checkOutput("post-reset 0x30C predict", {31'h0, predict}, 32'h0);
        checkOutput("post-reset 0x30C predict_pc", predict_pc, 32'h310);
        applyStimulus(lookupVec(32'h100, 1'b0, 32'h108));
        checkOutput("post-reset 0x100 predict_valid", {31'h0, predict_valid}, 32'h1);
        checkOutput("post-reset 0x100 predict", {31'h0, predict}, 32'h0);
        checkOutput("post-reset 0x100 predict_pc", predict_pc, 32'h108);
        idleInputs();
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor that generates the `predictIn`/`predictPCin` pair consumed by the branch execution unit, and consumes that unit's resolution bus `PCpipe` to train itself and issue a redirect on mispredict. It is a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. It sits between the fetch PC register and the branch pipe.

## Interface
- `ENTRIES`, 16: number of BTB entries; a power of two in 4..256.
- `IDX_W`, $clog2(ENTRIES): index width; derived, not overridden.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `fetch_valid` in 1: a lookup is requested this cycle.
- `fetch_pc` in [0:31]: word-aligned fetch PC; bits [30:31] are ignored.
- `predict_valid` out 1: `predict`/`predict_pc` carry a prediction for the previous cycle's lookup.
- `predict` out 1: predicted taken. Drives `predictIn` of the branch unit.
- `predict_pc` out [0:31]: predicted next PC. Drives `predictPCin`.
- `resolve_valid` in 1: `PCpipe` holds a resolved branch this cycle.
- `PCpipe` in [0:65]: branch resolution, laid out as follows.
  - [0:31]: correct next PC.
  - [32]: taken.
  - [33:64]: branch PC.
  - [65]: mispredict.
- `redirect` out 1: one-cycle pulse; fetch must restart at `redirect_pc`.
- `redirect_pc` out [0:31]: restart PC.
- `stat_branches` out [0:31]: resolved-branch count (see Configuration).
- `stat_mispredicts` out [0:31]: mispredict count (see Configuration).

## Operation
- **Entry fields:** `valid`, tag, target [0:31], ctr [0:1].
  - Index: `pc[30-IDX_W:29]`.
  - Tag: `pc[0:29-IDX_W]`.
- **Lookup.** Hit means `valid` is set and the tag matches. On `fetch_valid`:
  - If hit and ctr[0]==1: `predict`=1, `predict_pc`=entry target.
  - Otherwise: `predict`=0, `predict_pc`=(fetch_pc+8) & 32'hFFFF_FFF8. This is the same fall-through value the branch unit computes.
- **Counter encoding:**
  - 00: strong not-taken.
  - 01: weak not-taken.
  - 10: weak taken.
  - 11: strong taken.
- **Update.** Entry is selected by PCpipe[33:64].
  - Hit, PCpipe[32]=1: ctr increments, saturating at 11; target is written with PCpipe[0:31].
  - Hit, PCpipe[32]=0: ctr decrements, saturating at 00; target is unchanged.
  - Miss, PCpipe[32]=1: allocate the entry, overwriting any existing contents. Set `valid`=1, write the tag, set target=PCpipe[0:31], set ctr=10.
  - Miss, PCpipe[32]=0: the table is unchanged.
- **Redirect.** When `resolve_valid` and PCpipe[65] are both 1, `redirect_pc` is set to PCpipe[0:31].
- **Ignored inputs.** `PCpipe` is ignored whenever `resolve_valid`=0. The branch unit drives all zeros for non-branches.

## Timing
- **Reset:**
  - All `valid` bits are cleared and all ctr fields are set to 01.
  - `predict_valid`, `predict`, `predict_pc`, `redirect`, `redirect_pc` and both stats outputs reset to 0.
  - Reset asserted mid-operation aborts any pending redirect.
- **Lookup latency:** 1 cycle. The table is read combinationally at cycle N, and the outputs register at the N+1 edge.
  - `predict_valid`=`fetch_valid` delayed by one cycle.
  - Exception: `predict_valid` is forced to 0 in any cycle where `redirect`=1, because that lookup was on the wrong path.
- **Update latency:** the table write occurs at the edge that ends the `resolve_valid` cycle.
  - `redirect` asserts in the cycle after that edge, for exactly one cycle.
  - Back-to-back resolves each produce their own redirect pulse.
- **Simultaneous lookup and update to the same index:** the lookup returns the pre-update contents (read-before-write).
- **Back-to-back resolves to the same entry:** the second resolve sees the first one's write.

## Configuration
- `BP_STATS_EN`:
  - Defined: `stat_branches` increments on each `resolve_valid`. `stat_mispredicts` increments on each `resolve_valid` with PCpipe[65]=1. Both counters wrap modulo 2^32 and clear on reset.
  - Undefined: both ports are tied to 0 and no counter flops exist.
- Predictor behaviour is identical either way.

## Structure
- **Package `bp_pkg`:**
  - BTB entry struct.
  - Counter constants `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`.
  - `PCpipe` field index constants (TARGET, TAKEN, BRPC, MISP).
  - Fall-through alignment mask.
- **Sub-module `bp_sat_ctr`:** combinational 2-bit saturating next-state function (inputs: ctr, taken; output: next ctr), instantiated once in the update path.

## Test plan
- **Cold miss:** reset, then `fetch_valid`, `fetch_pc`=0x100 → next cycle `predict_valid`=1, `predict`=0, `predict_pc`=0x108.
- **Allocate, then hit:** resolve PCpipe{0x200, 1, 0x100, 1} → `redirect`=1 with `redirect_pc`=0x200 next cycle. Then lookup 0x100 → `predict`=1, `predict_pc`=0x200.
- **Saturation:**
  - Three taken resolves at 0x100 leave ctr=11.
  - Two not-taken resolves follow → ctr=01, and lookup gives `predict`=0.
  - Two further not-taken resolves → ctr stays 00.
- **Same-cycle conflict:** lookup 0x100 in the same cycle as the allocating resolve for 0x100 → `predict`=0 (old contents). Repeat the lookup one cycle later → `predict`=1.
- **Aliasing, ENTRIES=16:** allocate 0x100 → 0x200, then allocate 0x500 → 0x600. Lookup 0x100 → `predict`=0 (tag mismatch).
- **Redirect squash and reset:**
  - `fetch_valid` in the resolve cycle of a mispredict → `predict_valid`=0 in the `redirect` cycle.
  - Async reset asserted in the resolve cycle → `redirect` stays 0 and `stat_mispredicts`=0.
